// File: rtl/imem_ctrl.sv
// Instruction memory with post-reset clear sweep, program-load port and
// a 1-cycle-latency fetch port with stall hold and fault flags.
module imem_ctrl #(
  parameter int                   DEPTH    = 32,
  parameter int                   DATA_W   = 32,
  parameter logic [DATA_W-1:0]    NOP_WORD = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       prog_we,
  input  logic [$clog2(DEPTH)-1:0]   prog_addr,
  input  logic [DATA_W-1:0]          prog_data,
  input  logic                       prog_done,
  input  logic                       fetch_req,
  input  logic [31:0]                fetch_addr,
  input  logic                       stall,
  output logic                       fetch_ready,
  output logic                       instr_valid,
  output logic [DATA_W-1:0]          instr,
  output logic                       fault_misalign,
  output logic                       fault_range,
  output logic                       busy
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [30:0] DEPTH_EXT = 31'(DEPTH);

  typedef enum logic [1:0] {S_CLEAR, S_LOAD, S_RUN} state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_clr_cnt;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [DATA_W-1:0]   r_instr;
  logic                r_valid;
  logic                r_mis;
  logic                r_rng;

  logic                w_accept;
  logic                w_mis;
  logic                w_rng;
  logic [29:0]         w_word;
  logic [ADDR_W-1:0]   w_raddr;
  logic                w_we;
  logic [ADDR_W-1:0]   w_waddr;
  logic [DATA_W-1:0]   w_wdata;

  assign fetch_ready    = (r_state == S_RUN) && !stall;
  assign busy           = (r_state != S_RUN);
  assign instr          = r_instr;
  assign instr_valid    = r_valid;
  assign fault_misalign = r_mis;
  assign fault_range    = r_rng;

  assign w_accept = fetch_req && fetch_ready;
  assign w_word   = fetch_addr[31:2];
  assign w_raddr  = fetch_addr[ADDR_W+1:2];
  assign w_mis    = (fetch_addr[1:0] != 2'b00);
  // Range test uses every upper address bit so aliases above DEPTH are caught.
  assign w_rng    = ({1'b0, w_word} >= DEPTH_EXT);

  // Single write port shared by the clear sweep and the program loader.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = '0;
    w_wdata = '0;
    if (r_state == S_CLEAR) begin
      w_we    = 1'b1;
      w_waddr = r_clr_cnt;
      w_wdata = NOP_WORD;
    end else if (r_state == S_LOAD && prog_we) begin
      w_we    = 1'b1;
      w_waddr = prog_addr;
      w_wdata = prog_data;
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_CLEAR;
      r_clr_cnt <= '0;
      r_instr   <= '0;
      r_valid   <= 1'b0;
      r_mis     <= 1'b0;
      r_rng     <= 1'b0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          r_clr_cnt <= r_clr_cnt + 1'b1;
          if (r_clr_cnt == ADDR_W'(DEPTH - 1)) r_state <= S_LOAD;
        end
        S_LOAD: begin
          if (prog_done) r_state <= S_RUN;
        end
        S_RUN: begin
          if (w_accept) begin
            r_valid <= 1'b1;
            r_mis   <= w_mis;
            r_rng   <= w_rng;
            r_instr <= (w_mis || w_rng) ? NOP_WORD : r_mem[w_raddr];
          end else if (!stall) begin
            r_valid <= 1'b0;
          end
        end
        default: r_state <= S_CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_ctrl.sv
// Scoreboard bench for imem_ctrl: expected fetch results are queued at accept
// and popped when the DUT presents them one cycle later.
module tb_imem_ctrl;

  localparam int DEPTH  = 32;
  localparam int DATA_W = 32;
  localparam int AW     = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              prog_we;
  logic [AW-1:0]     prog_addr;
  logic [DATA_W-1:0] prog_data;
  logic              prog_done;
  logic              fetch_req;
  logic [31:0]       fetch_addr;
  logic              stall;
  logic              fetch_ready;
  logic              instr_valid;
  logic [DATA_W-1:0] instr;
  logic              fault_misalign;
  logic              fault_range;
  logic              busy;

  imem_ctrl #(
    .DEPTH   (DEPTH),
    .DATA_W  (DATA_W),
    .NOP_WORD(32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .prog_we       (prog_we),
    .prog_addr     (prog_addr),
    .prog_data     (prog_data),
    .prog_done     (prog_done),
    .fetch_req     (fetch_req),
    .fetch_addr    (fetch_addr),
    .stall         (stall),
    .fetch_ready   (fetch_ready),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .fault_misalign(fault_misalign),
    .fault_range   (fault_range),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic        mis;
    logic        rng;
  } exp_t;

  exp_t        sbq[$];
  exp_t        hold;
  logic        hold_v;
  logic [31:0] mdl [DEPTH];
  logic        run_mode;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".valid"}, 32'(instr_valid), 32'(hold_v));
    check({tag, ".instr"}, instr, hold.instr);
    check({tag, ".mis"},   32'(fault_misalign), 32'(hold.mis));
    check({tag, ".rng"},   32'(fault_range), 32'(hold.rng));
  endtask

  // One RUN-phase cycle; inputs applied 1 time unit after the previous edge.
  task automatic fetch_cycle(input string tag, input logic req, input logic [31:0] addr,
                             input logic stl);
    logic        acc;
    logic [29:0] up;
    exp_t        e;
    fetch_req  = req;
    fetch_addr = addr;
    stall      = stl;
    #1;
    check({tag, ".ready"}, 32'(fetch_ready), 32'(run_mode && !stl));
    acc = req && run_mode && !stl;
    if (acc) begin
      up      = addr[31:2];
      e.mis   = (addr[1:0] != 2'b00);
      e.rng   = (up >= 30'(DEPTH));
      e.instr = (e.mis || e.rng) ? 32'h0 : mdl[addr[6:2]];
      sbq.push_back(e);
    end
    @(posedge clk); #1;
    if (acc) begin
      if (sbq.size() == 0) begin
        check({tag, ".sbq_empty"}, 32'd1, 32'd0);
      end else begin
        hold   = sbq.pop_front();
        hold_v = 1'b1;
      end
    end else if (!stl) begin
      hold_v = 1'b0;
    end
    check_outputs(tag);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    hold     = '0;
    hold_v   = 1'b0;
    run_mode = 1'b0;
    sbq.delete();
    for (int i = 0; i < DEPTH; i++) mdl[i] = 32'h0;
    check_outputs("rst");
    check("rst.busy",  32'(busy), 32'd1);
    check("rst.ready", 32'(fetch_ready), 32'd0);
  endtask

  // Release reset and walk the clear sweep with every ignored input held active.
  task automatic clear_phase();
    fetch_req  = 1'b1;
    fetch_addr = 32'h0;
    stall      = 1'b0;
    prog_we    = 1'b1;
    prog_addr  = AW'(3);
    prog_data  = 32'hDEAD_BEEF;
    prog_done  = 1'b1;
    rst_n      = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      check("clr.busy",  32'(busy), 32'd1);
      check("clr.ready", 32'(fetch_ready), 32'd0);
      @(posedge clk); #1;
      check("clr.valid", 32'(instr_valid), 32'd0);
    end
    prog_we   = 1'b0;
    prog_done = 1'b0;
    fetch_req = 1'b0;
    #1;
    check("load.busy",  32'(busy), 32'd1);
    check("load.ready", 32'(fetch_ready), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    prog_we = 1'b0; prog_addr = '0; prog_data = '0; prog_done = 1'b0;
    fetch_req = 1'b0; fetch_addr = '0; stall = 1'b0;
    apply_reset();
    repeat (2) @(posedge clk);
    #1;
    clear_phase();

    // Idle LOAD cycle, then two writes with prog_done on the second.
    @(posedge clk); #1;
    check("load.idle_ready", 32'(fetch_ready), 32'd0);
    prog_we = 1'b1; prog_addr = AW'(0); prog_data = 32'hD92A_4015;
    @(posedge clk); #1;
    mdl[0] = 32'hD92A_4015;
    prog_addr = AW'(1); prog_data = 32'h1234_5678; prog_done = 1'b1;
    @(posedge clk); #1;
    mdl[1] = 32'h1234_5678;
    prog_we = 1'b0; prog_done = 1'b0;
    run_mode = 1'b1;
    check("run.busy", 32'(busy), 32'd0);

    fetch_cycle("f0",     1'b1, 32'h0000_0000, 1'b0);
    fetch_cycle("f4",     1'b1, 32'h0000_0004, 1'b0);
    fetch_cycle("f6",     1'b1, 32'h0000_0006, 1'b0);
    fetch_cycle("f83",    1'b1, 32'h0000_0083, 1'b0);
    fetch_cycle("f80",    1'b1, 32'h0000_0080, 1'b0);
    fetch_cycle("f7c",    1'b1, 32'h0000_007C, 1'b0);
    fetch_cycle("fC",     1'b1, 32'h0000_000C, 1'b0);
    fetch_cycle("fhigh",  1'b1, 32'h8000_0004, 1'b0);
    fetch_cycle("fhigh2", 1'b1, 32'h0000_1004, 1'b0);
    fetch_cycle("idle",   1'b0, 32'h0000_0000, 1'b0);

    // Writes and prog_done are ignored in RUN.
    prog_we = 1'b1; prog_addr = AW'(0); prog_data = 32'hFFFF_FFFF; prog_done = 1'b1;
    fetch_cycle("runwr",  1'b0, 32'h0000_0000, 1'b0);
    prog_we = 1'b0; prog_done = 1'b0;
    fetch_cycle("f0b",    1'b1, 32'h0000_0000, 1'b0);

    // Stall hold after a good fetch, then a faulted fetch under stall.
    fetch_cycle("f4b",    1'b1, 32'h0000_0004, 1'b0);
    for (int i = 0; i < 3; i++) fetch_cycle("stall", 1'b1, 32'h0000_0006, 1'b1);
    fetch_cycle("post",   1'b1, 32'h0000_0000, 1'b0);
    fetch_cycle("f6b",    1'b1, 32'h0000_0006, 1'b0);
    fetch_cycle("stallf", 1'b0, 32'h0000_0000, 1'b1);
    fetch_cycle("clean",  1'b1, 32'h0000_0004, 1'b0);

    // Asynchronous reset mid-RUN, re-clear, no load, fetch returns the cleared word.
    apply_reset();
    @(posedge clk); #1;
    clear_phase();
    prog_done = 1'b1;
    @(posedge clk); #1;
    prog_done = 1'b0;
    run_mode  = 1'b1;
    fetch_cycle("rf0",    1'b1, 32'h0000_0000, 1'b0);
    fetch_cycle("rf4",    1'b1, 32'h0000_0004, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
